banked_mem_stage: RTL and testbench
===================================

BANKED_MEM_STAGE -- requirements
Module: banked_mem_stage

Interface
REQ-001 Parameter N, 32, data and address width in bits; SHALL be a multiple of 8.
REQ-002 Parameter BANKS, 4, number of data-memory banks; SHALL be 1..2^(N-DEPTH_BITS).
REQ-003 Parameter DEPTH_BITS, 16, word-index bits per bank; each bank holds 2^DEPTH_BITS words of N bits.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 write_enable  input  1  1 = write request, 0 = read request.
REQ-009 byte_enable  input  N/8  per-byte write mask; ignored for reads.
REQ-010 address  input  N  [N-1:DEPTH_BITS] bank select, [DEPTH_BITS-1:0] word index.
REQ-011 write_data  input  N  write data.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts response this cycle.
REQ-014 read_data  output  N  read result; 0 for writes and errored requests.
REQ-015 addr_error  output  1  response is for a bank select >= BANKS.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; one request per cycle maximum.
REQ-017 req_ready SHALL equal !reset && (!resp_valid || resp_ready).
REQ-018 Every accepted request (read or write) SHALL produce exactly one response, resp_valid=1 the cycle after acceptance (latency 1).
REQ-019 Accepted write with bank select < BANKS SHALL update byte i of the addressed word iff byte_enable[i]=1, committed at the accepting edge; other bytes and words unchanged.
REQ-020 byte_enable all zero on a write SHALL leave memory unchanged and still produce a response.
REQ-021 Accepted read with bank select < BANKS SHALL return the addressed word, including any write accepted on any earlier edge.
REQ-022 Bank select >= BANKS SHALL cause no memory change; response has addr_error=1, read_data=0.
REQ-023 Write responses SHALL have read_data=0, addr_error=0 when in range.
REQ-024 While resp_valid=1 and resp_ready=0, read_data, addr_error and resp_valid SHALL hold stable and no request SHALL be accepted.
REQ-025 resp_valid=1 and resp_ready=1 with req_valid=1 SHALL retire the old response and accept the new one on the same edge (full throughput, back-to-back).
REQ-026 resp_ready=1 with no new request SHALL clear resp_valid on that edge.
REQ-027 Word index SHALL not wrap into an adjacent bank; bank select and word index are decoded independently.
REQ-028 Control state SHALL be a two-state machine: EMPTY (resp_valid=0) and FULL (resp_valid=1); EMPTY->FULL on accept, FULL->FULL on accept-with-retire or stall, FULL->EMPTY on retire without accept.
REQ-029 Memory arrays SHALL be inferable synchronous RAMs, one per bank; only the accepted request's bank SHALL be write-enabled.

Reset
REQ-030 reset=1 at a rising edge SHALL force resp_valid=0, read_data=0, addr_error=0, state EMPTY.
REQ-031 While reset=1, req_ready=0; no request accepted and no memory write occurs, even with req_valid=1.
REQ-032 reset mid-operation SHALL discard any pending response without delivering it.
REQ-033 reset SHALL NOT clear memory contents.

Verification (N=32, BANKS=4, DEPTH_BITS=16)
REQ-034 Write 0xDEADBEEF to 0x0002_0010, be=0xF; read 0x0002_0010 -> resp next cycle, read_data=0xDEADBEEF, addr_error=0; read 0x0001_0010 unaffected.
REQ-035 After REQ-034, write 0x11223344 to 0x0002_0010 with be=0x5; read -> 0xDE22BE44.
REQ-036 Read 0x0004_0000 and write 0xFFFFFFFF to 0x0007_0000 -> each response addr_error=1, read_data=0; banks 0..3 unchanged.
REQ-037 Read issued with resp_ready=0 for 3 cycles -> resp_valid and read_data stable, req_ready=0; resp_ready=1 retires; 4 back-to-back reads with resp_ready=1 -> 4 responses on 4 consecutive cycles.
REQ-038 Read accepted, reset asserted next cycle with resp_ready=0 and req_valid=1 write to 0x0000_0000 -> resp_valid=0 after reset, word 0x0000_0000 unchanged, earlier contents intact.

Source files
------------

// File: rtl/banked_mem_stage.sv
// Banked data-memory stage: one request per cycle into BANKS byte-writable RAMs,
// with a single registered response slot that holds under consumer back-pressure.
module banked_mem_stage #(
  parameter int N          = 32,
  parameter int BANKS      = 4,
  parameter int DEPTH_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                write_enable,
  input  logic [N/8-1:0]      byte_enable,
  input  logic [N-1:0]        address,
  input  logic [N-1:0]        write_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [N-1:0]        read_data,
  output logic                addr_error
);

  localparam int SEL_W  = N - DEPTH_BITS;
  localparam int BIDX_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int NB     = N / 8;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_next;

  logic [SEL_W-1:0]      bank_sel;
  logic [DEPTH_BITS-1:0] word_idx;
  logic                  in_range;
  logic                  accept;
  logic                  retire;

  logic                  rd_ok_q;
  logic                  err_q;
  logic [BIDX_W-1:0]     bank_q;
  logic [N-1:0]          bank_rdata [BANKS];

  // Bank select and word index are decoded independently, so an index never
  // carries into the neighbouring bank.
  assign bank_sel = address[N-1:DEPTH_BITS];
  assign word_idx = address[DEPTH_BITS-1:0];
  assign in_range = ({1'b0, bank_sel} < (SEL_W+1)'(BANKS));

  assign resp_valid = (state == FULL);
  assign req_ready  = !reset && (!resp_valid || resp_ready);
  assign accept     = req_valid && req_ready;
  assign retire     = resp_valid && resp_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (retire && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Response attributes only change on accept, which keeps them stable during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
      bank_q  <= '0;
    end else if (accept) begin
      rd_ok_q <= !write_enable && in_range;
      err_q   <= !in_range;
      bank_q  <= bank_sel[BIDX_W-1:0];
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [N-1:0] mem [2**DEPTH_BITS];
    logic [N-1:0] rdata_q;
    logic         hit;

    assign hit = accept && in_range && (bank_sel == SEL_W'(b));

    // NOTE: RAM contents and the RAM output register are deliberately not
    // reset; a reset port would prevent block-RAM inference and must not
    // disturb stored data anyway.
    always_ff @(posedge clk) begin
      if (hit && write_enable) begin
        for (int i = 0; i < NB; i++) begin
          if (byte_enable[i]) mem[word_idx][i*8 +: 8] <= write_data[i*8 +: 8];
        end
      end
      if (hit && !write_enable) rdata_q <= mem[word_idx];
    end

    assign bank_rdata[b] = rdata_q;
  end

  // Only an in-range read shows RAM data; writes, errors and idle cycles read as zero.
  always_comb begin
    read_data = '0;
    if (resp_valid && rd_ok_q) begin
      for (int b = 0; b < BANKS; b++) begin
        if (bank_q == BIDX_W'(b)) read_data = bank_rdata[b];
      end
    end
  end

  assign addr_error = resp_valid && err_q;

endmodule

// File: tb/tb_banked_mem_stage.sv
// Bench for banked_mem_stage: table of requests with hand-derived expectations,
// a response scoreboard, and hand sequences for stall, back-to-back and reset.
module tb_banked_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        write_enable;
  logic [3:0]  byte_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] read_data;
  logic        addr_error;

  banked_mem_stage #(.N(32), .BANKS(4), .DEPTH_BITS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .write_enable (write_enable),
    .byte_enable  (byte_enable),
    .address      (address),
    .write_data   (write_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .read_data    (read_data),
    .addr_error   (addr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   resp_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a response is consumed at the negedge before the edge that retires it.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      resp_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", read_data, e.data);
        check("resp_err", {31'd0, addr_error}, {31'd0, e.err});
      end
    end
  end

  // Drive one request starting just after a posedge; returns just after the accepting edge.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err, input bit push);
    int k;
    req_valid    = 1'b1;
    write_enable = we;
    byte_enable  = be;
    address      = addr;
    write_data   = wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 20) check("req_ready_timeout", 32'd0, 32'd1);
    if (push) sb.push_back('{data: exp_data, err: exp_err});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    req_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    reset        = 1'b1;
    req_valid    = 1'b1;
    write_enable = 1'b1;
    byte_enable  = 4'hF;
    address      = 32'h0001_0010;
    write_data   = 32'h5555_5555;
    resp_ready   = 1'b0;

    // Reset state, with a write request pending that must not be accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_addr_error", {31'd0, addr_error}, 32'd0);
    @(posedge clk); #1;
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;

    vecs.push_back('{1'b1, 4'hF, 32'h0001_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0000, 32'h0101_0101, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0003_0000, 32'h0303_0303, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0001_0000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0002_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0002_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 4'h0, 32'h0001_0010, 32'h0000_0000, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 4'h5, 32'h0002_0010, 32'h1122_3344, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0002_0010, 32'h0000_0000, 32'hDE22_BE44, 1'b0});
    vecs.push_back('{1'b1, 4'h0, 32'h0002_0010, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0002_0010, 32'h0000_0000, 32'hDE22_BE44, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0004_0000, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 4'hF, 32'h0007_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h0101_0101, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0003_0000, 32'h0000_0000, 32'h0303_0303, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_FFFF, 32'h7777_7777, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0001_0000, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b0, 4'hF, 32'h0000_FFFF, 32'h0000_0000, 32'h7777_7777, 1'b0});
    vecs.push_back('{1'b1, 4'hF, 32'hFFFF_0000, 32'h1234_5678, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 4'hF, 32'h0003_0000, 32'h0000_0000, 32'h0303_0303, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_data, vecs[i].exp_err, 1'b1);
    end
    drain();

    // Stall: response held for 3 cycles while a write is offered and must be refused.
    resp_ready = 1'b0;
    issue(1'b0, 4'hF, 32'h0002_0010, 32'h0, 32'hDE22_BE44, 1'b0, 1'b1);
    req_valid    = 1'b1;
    write_enable = 1'b1;
    byte_enable  = 4'hF;
    address      = 32'h0003_0000;
    write_data   = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_read_data", read_data, 32'hDE22_BE44);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("retire_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;

    // Four back-to-back reads must produce responses on consecutive cycles.
    n0 = resp_cyc.size();
    issue(1'b0, 4'hF, 32'h0003_0000, 32'h0, 32'h0303_0303, 1'b0, 1'b1);
    issue(1'b0, 4'hF, 32'h0001_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue(1'b0, 4'hF, 32'h0002_0010, 32'h0, 32'hDE22_BE44, 1'b0, 1'b1);
    issue(1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0101_0101, 1'b0, 1'b1);
    drain();
    check("b2b_count", resp_cyc.size() - n0, 32'd4);
    if (resp_cyc.size() - n0 == 4) begin
      for (int i = 1; i < 4; i++) check("b2b_gap", resp_cyc[n0+i] - resp_cyc[n0+i-1], 32'd1);
    end

    // Reset with a pending response and a write offered: response dropped, memory kept.
    resp_ready = 1'b0;
    issue(1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    reset        = 1'b1;
    req_valid    = 1'b1;
    write_enable = 1'b1;
    byte_enable  = 4'hF;
    address      = 32'h0000_0000;
    write_data   = 32'hBADB_ADBA;
    @(negedge clk);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rst_read_data", read_data, 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 4'hF, 32'h0000_0000, 32'h0, 32'h0101_0101, 1'b0, 1'b1);
    issue(1'b0, 4'hF, 32'h0003_0000, 32'h0, 32'h0303_0303, 1'b0, 1'b1);
    issue(1'b0, 4'hF, 32'h0002_0010, 32'h0, 32'hDE22_BE44, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
